// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: channel state encoding,
// default timing parameters and a small state-decode helper.
package button_conditioner_pkg;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t IDLE         = 2'd0;
  localparam chan_state_t PRESS_WAIT   = 2'd1;
  localparam chan_state_t HELD         = 2'd2;
  localparam chan_state_t RELEASE_WAIT = 2'd3;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;
  localparam int DEFAULT_CNT_W           = 20;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  // The debounced level is "pressed" while a release has not yet been confirmed.
  function automatic logic state_is_held(input chan_state_t state);
    return (state == HELD) || (state == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: input synchroniser, debounce FSM with stability counter,
// a one-cycle press request and the registered debounced level.
module button_conditioner_debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press_req,
  output logic held
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s;
  chan_state_t            state_r;
  chan_state_t            next_state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       next_cnt_s;
  logic                   press_req_r;
  logic                   next_press_req_s;
  logic                   held_r;
  logic                   next_held_s;

  assign s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous raw button level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      press_req_r <= 1'b0;
      held_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cnt_r       <= next_cnt_s;
      press_req_r <= next_press_req_s;
      held_r      <= next_held_s;
    end
  end

  // Next-state and counter logic; the counter restarts on every state entry
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (s) begin
          next_state_s = PRESS_WAIT;
          next_cnt_s   = '0;
        end else begin
          next_state_s = IDLE;
          next_cnt_s   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          next_state_s = IDLE;
          next_cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = HELD;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s) begin
          next_state_s = RELEASE_WAIT;
          next_cnt_s   = '0;
        end else begin
          next_state_s = HELD;
          next_cnt_s   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          next_state_s = HELD;
          next_cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = IDLE;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        next_state_s = IDLE;
        next_cnt_s   = '0;
      end
    endcase
  end

  // Output decode: a request only on the PRESS_WAIT -> HELD transition
  always_comb begin
    next_press_req_s = (state_r == PRESS_WAIT) && s && (cnt_r == CNT_LAST);
    next_held_s      = state_is_held(next_state_s);
  end

  assign press_req = press_req_r;
  assign held      = held_r;

endmodule

// File: rtl/button_conditioner.sv
// Two debounced button channels feeding a registered arbiter that emits one
// press pulse per accepted press and locks out chords between the buttons.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_higher_raw,
  input  logic btn_lower_raw,
  output logic btn_higher,
  output logic btn_lower,
  output logic higher_held,
  output logic lower_held
);

  logic press_req_h;
  logic press_req_l;
  logic higher_held_int;
  logic lower_held_int;
  logic btn_higher_r;
  logic btn_lower_r;
  logic higher_held_r;
  logic lower_held_r;

  button_conditioner_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_higher (
    .clk       (clk),
    .reset     (reset),
    .raw       (btn_higher_raw),
    .press_req (press_req_h),
    .held      (higher_held_int)
  );

  button_conditioner_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_lower (
    .clk       (clk),
    .reset     (reset),
    .raw       (btn_lower_raw),
    .press_req (press_req_l),
    .held      (lower_held_int)
  );

  // Arbitration: simultaneous requests cancel, and a button already down
  // on the other channel blocks the new press entirely
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_higher_r  <= 1'b0;
      btn_lower_r   <= 1'b0;
      higher_held_r <= 1'b0;
      lower_held_r  <= 1'b0;
    end else begin
      btn_higher_r  <= press_req_h & ~press_req_l & ~lower_held_int;
      btn_lower_r   <= press_req_l & ~press_req_h & ~higher_held_int;
      higher_held_r <= higher_held_int;
      lower_held_r  <= lower_held_int;
    end
  end

  assign btn_higher  = btn_higher_r;
  assign btn_lower   = btn_lower_r;
  assign higher_held = higher_held_r;
  assign lower_held  = lower_held_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// a clean press pulses on edge 7 after the first sampling edge.
module tb_button_conditioner;

  logic clk;
  logic reset;
  logic btn_higher_raw;
  logic btn_lower_raw;
  logic btn_higher;
  logic btn_lower;
  logic higher_held;
  logic lower_held;

  int checks;
  int failures;

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20),
    .SYNC_STAGES     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_higher_raw (btn_higher_raw),
    .btn_lower_raw  (btn_lower_raw),
    .btn_higher     (btn_higher),
    .btn_lower      (btn_lower),
    .higher_held    (higher_held),
    .lower_held     (lower_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_higher_raw = 1'b0;
    btn_lower_raw = 1'b0;
    repeat (3) tick();
    checks++; if (btn_higher !== 1'b0) begin failures++; $display("FAIL reset_btn_higher got=%b exp=0", btn_higher); end
    checks++; if (btn_lower !== 1'b0) begin failures++; $display("FAIL reset_btn_lower got=%b exp=0", btn_lower); end
    checks++; if (higher_held !== 1'b0) begin failures++; $display("FAIL reset_higher_held got=%b exp=0", higher_held); end
    checks++; if (lower_held !== 1'b0) begin failures++; $display("FAIL reset_lower_held got=%b exp=0", lower_held); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_clean_press();
    btn_higher_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (btn_higher !== (k == 7)) begin failures++; $display("FAIL clean_pulse cycle=%0d got=%b exp=%b", k, btn_higher, (k == 7)); end
      checks++; if (higher_held !== (k >= 7)) begin failures++; $display("FAIL clean_held cycle=%0d got=%b exp=%b", k, higher_held, (k >= 7)); end
      checks++; if (btn_lower !== 1'b0) begin failures++; $display("FAIL clean_no_lower cycle=%0d got=%b exp=0", k, btn_lower); end
    end
    btn_higher_raw = 1'b0;
    repeat (12) tick();
    checks++; if (higher_held !== 1'b0) begin failures++; $display("FAIL clean_release_held got=%b exp=0", higher_held); end
  endtask

  task automatic test_bounce();
    logic [7:0] pattern;
    int pulses;
    int held_seen;
    int first_pulse;
    pattern = 8'b0111_0111;
    pulses = 0;
    held_seen = 0;
    for (int k = 0; k < 18; k++) begin
      btn_higher_raw = (k < 8) ? pattern[7-k] : 1'b0;
      tick();
      pulses += int'(btn_higher);
      held_seen += int'(higher_held);
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
    checks++; if (held_seen !== 0) begin failures++; $display("FAIL bounce_held got=%0d exp=0", held_seen); end
    // A fresh press only has the nominal latency if the channel is back in IDLE
    btn_higher_raw = 1'b1;
    pulses = 0;
    first_pulse = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (btn_higher && first_pulse < 0) first_pulse = k;
      pulses += int'(btn_higher);
    end
    checks++; if (first_pulse !== 7) begin failures++; $display("FAIL bounce_idle_latency got=%0d exp=7", first_pulse); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL bounce_idle_pulses got=%0d exp=1", pulses); end
    btn_higher_raw = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_long_hold();
    logic [9:0] glitch;
    int pulses_l;
    int pulses_h;
    glitch = 10'b0001100011;
    pulses_l = 0;
    pulses_h = 0;
    btn_lower_raw = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      pulses_l += int'(btn_lower);
      pulses_h += int'(btn_higher);
    end
    checks++; if (pulses_l !== 1) begin failures++; $display("FAIL hold_lower_pulses got=%0d exp=1", pulses_l); end
    checks++; if (pulses_h !== 0) begin failures++; $display("FAIL hold_higher_pulses got=%0d exp=0", pulses_h); end
    checks++; if (lower_held !== 1'b1) begin failures++; $display("FAIL hold_lower_held got=%b exp=1", lower_held); end
    pulses_l = 0;
    for (int k = 0; k < 20; k++) begin
      btn_lower_raw = (k < 10) ? glitch[9-k] : 1'b0;
      tick();
      pulses_l += int'(btn_lower);
    end
    checks++; if (pulses_l !== 0) begin failures++; $display("FAIL glitch_release_pulses got=%0d exp=0", pulses_l); end
    checks++; if (lower_held !== 1'b0) begin failures++; $display("FAIL glitch_release_held got=%b exp=0", lower_held); end
    btn_lower_raw = 1'b1;
    pulses_l = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      pulses_l += int'(btn_lower);
    end
    checks++; if (pulses_l !== 1) begin failures++; $display("FAIL repress_pulses got=%0d exp=1", pulses_l); end
    btn_lower_raw = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_simultaneous();
    int pulses_h;
    int pulses_l;
    pulses_h = 0;
    pulses_l = 0;
    btn_higher_raw = 1'b1;
    btn_lower_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      pulses_h += int'(btn_higher);
      pulses_l += int'(btn_lower);
    end
    checks++; if (pulses_h !== 0) begin failures++; $display("FAIL simul_higher_pulses got=%0d exp=0", pulses_h); end
    checks++; if (pulses_l !== 0) begin failures++; $display("FAIL simul_lower_pulses got=%0d exp=0", pulses_l); end
    checks++; if (higher_held !== 1'b1) begin failures++; $display("FAIL simul_higher_held got=%b exp=1", higher_held); end
    checks++; if (lower_held !== 1'b1) begin failures++; $display("FAIL simul_lower_held got=%b exp=1", lower_held); end
    btn_higher_raw = 1'b0;
    btn_lower_raw = 1'b0;
    repeat (12) tick();
    pulses_h = 0;
    pulses_l = 0;
    btn_higher_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      pulses_h += int'(btn_higher);
      pulses_l += int'(btn_lower);
    end
    checks++; if (pulses_h !== 1) begin failures++; $display("FAIL after_simul_higher got=%0d exp=1", pulses_h); end
    checks++; if (pulses_l !== 0) begin failures++; $display("FAIL after_simul_lower got=%0d exp=0", pulses_l); end
    btn_higher_raw = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_chord_lockout();
    int pulses_h;
    int pulses_l;
    pulses_h = 0;
    pulses_l = 0;
    btn_higher_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      pulses_h += int'(btn_higher);
    end
    checks++; if (higher_held !== 1'b1) begin failures++; $display("FAIL chord_higher_held got=%b exp=1", higher_held); end
    checks++; if (pulses_h !== 1) begin failures++; $display("FAIL chord_higher_pulses got=%0d exp=1", pulses_h); end
    pulses_h = 0;
    btn_lower_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      pulses_h += int'(btn_higher);
      pulses_l += int'(btn_lower);
    end
    checks++; if (pulses_l !== 0) begin failures++; $display("FAIL chord_lower_pulses got=%0d exp=0", pulses_l); end
    checks++; if (pulses_h !== 0) begin failures++; $display("FAIL chord_higher_repulse got=%0d exp=0", pulses_h); end
    checks++; if (lower_held !== 1'b1) begin failures++; $display("FAIL chord_lower_held got=%b exp=1", lower_held); end
    btn_higher_raw = 1'b0;
    btn_lower_raw = 1'b0;
    repeat (12) tick();
    checks++; if (higher_held !== 1'b0) begin failures++; $display("FAIL chord_release_higher got=%b exp=0", higher_held); end
    checks++; if (lower_held !== 1'b0) begin failures++; $display("FAIL chord_release_lower got=%b exp=0", lower_held); end
  endtask

  task automatic test_reset_mid_operation();
    int first_pulse;
    int pulses;
    btn_higher_raw = 1'b1;
    repeat (5) tick();
    // Edge 4 leaves the channel in PRESS_WAIT with cnt=2
    reset = 1'b1;
    #1;
    checks++; if ({btn_higher, btn_lower, higher_held, lower_held} !== 4'b0000) begin failures++; $display("FAIL reset_mid_outputs got=%b exp=0000", {btn_higher, btn_lower, higher_held, lower_held}); end
    repeat (2) tick();
    checks++; if (btn_higher !== 1'b0) begin failures++; $display("FAIL reset_mid_no_pulse got=%b exp=0", btn_higher); end
    reset = 1'b0;
    first_pulse = -1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (btn_higher && first_pulse < 0) first_pulse = k;
      pulses += int'(btn_higher);
    end
    checks++; if (first_pulse !== 7) begin failures++; $display("FAIL post_reset_latency got=%0d exp=7", first_pulse); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL post_reset_pulses got=%0d exp=1", pulses); end
    checks++; if (higher_held !== 1'b1) begin failures++; $display("FAIL post_reset_held got=%b exp=1", higher_held); end
    // Asynchronous assertion must clear the held level without waiting for a clock edge
    #2;
    reset = 1'b1;
    #1;
    checks++; if (higher_held !== 1'b0) begin failures++; $display("FAIL reset_async_held got=%b exp=0", higher_held); end
    btn_higher_raw = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_simultaneous();
    test_chord_lockout();
    test_reset_mid_operation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
